// File: rtl/rtc_bus_sequencer.sv
// Bus master for the multiplexed address/data RTC interface: runs single or
// burst register transfers as ADDR/GAP1/DATA/GAP2 beats with registered strobes.
module rtc_bus_sequencer #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter int PHASE_CYC = 4,
  parameter int GAP_CYC   = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic              wr_nrd,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_req,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              CS,
  output logic              AD,
  output logic              WR,
  output logic              RD,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in
);

  localparam int PH_MAX = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] PH_LOAD = PH_W'(PHASE_CYC - 1);
  localparam logic [PH_W-1:0] GP_LOAD = PH_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   phase_cnt, phase_nxt;
  logic [DATA_W-1:0] addr, addr_nxt;
  logic [CNT_W-1:0]  beats, beats_nxt;
  logic              wr_mode, wr_mode_nxt;
  logic              phase_end;
  logic              rd_capture;
  logic              nxt_active;

  assign phase_end  = (phase_cnt == '0);
  assign wdata_req  = (state == S_GAP1) && wr_mode && phase_end;
  assign rd_capture = (state == S_DATA) && !wr_mode && phase_end;
  assign nxt_active = (state_nxt == S_ADDR) || (state_nxt == S_GAP1) ||
                      (state_nxt == S_DATA) || (state_nxt == S_GAP2);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      addr      <= '0;
      beats     <= '0;
      wr_mode   <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      addr      <= addr_nxt;
      beats     <= beats_nxt;
      wr_mode   <= wr_mode_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    beats_nxt   = beats;
    wr_mode_nxt = wr_mode;
    case (state)
      S_IDLE: begin
        if (start) begin
          wr_mode_nxt = wr_nrd;
          addr_nxt    = base_addr;
          beats_nxt   = count;
          state_nxt   = (count == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: if (phase_end) state_nxt = S_GAP1;
      S_GAP1: if (phase_end) state_nxt = S_DATA;
      S_DATA: if (phase_end) state_nxt = S_GAP2;
      S_GAP2: begin
        if (phase_end) begin
          addr_nxt  = addr + DATA_W'(1);
          beats_nxt = beats - CNT_W'(1);
          state_nxt = (beats == CNT_W'(1)) ? S_DONE : S_ADDR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single phase counter, reloaded whenever the state changes.
  always_comb begin
    phase_nxt = phase_cnt - PH_W'(1);
    if (state_nxt != state) begin
      case (state_nxt)
        S_ADDR, S_DATA: phase_nxt = PH_LOAD;
        S_GAP1, S_GAP2: phase_nxt = GP_LOAD;
        default:        phase_nxt = '0;
      endcase
    end else if (state == S_IDLE || state == S_DONE) begin
      phase_nxt = '0;
    end
  end

  // Pad-facing outputs are decoded from the next state so they line up with it.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CS          <= 1'b1;
      AD          <= 1'b1;
      WR          <= 1'b1;
      RD          <= 1'b1;
      bus_oe      <= 1'b0;
      bus_out     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      CS          <= 1'b1;
      AD          <= 1'b1;
      WR          <= 1'b1;
      RD          <= 1'b1;
      bus_oe      <= 1'b0;
      busy        <= nxt_active;
      done        <= (state_nxt == S_DONE);
      rdata_valid <= rd_capture;
      if (rd_capture) rdata <= bus_in;
      case (state_nxt)
        S_ADDR: begin
          CS      <= 1'b0;
          AD      <= 1'b0;
          WR      <= 1'b0;
          bus_oe  <= 1'b1;
          bus_out <= addr_nxt;
        end
        S_DATA: begin
          CS <= 1'b0;
          if (wr_mode) begin
            WR     <= 1'b0;
            bus_oe <= 1'b1;
          end else begin
            RD <= 1'b0;
          end
        end
        default: ;
      endcase
      if (wdata_req) bus_out <= wdata;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: default-timing and PHASE_CYC=1/GAP_CYC=2 instances,
// compared cycle by cycle against a transaction-level pin trace model.
module tb_rtc_bus_sequencer;

  localparam int PA = 4, GA = 1;
  localparam int PB = 1, GB = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b, wr_nrd;
  logic [7:0] base_addr, wdata, bus_in;
  logic [3:0] count;

  logic       a_wreq, a_rvld, a_busy, a_done, a_cs, a_ad, a_wr, a_rd, a_oe;
  logic [7:0] a_rdata, a_bout;
  logic       b_wreq, b_rvld, b_busy, b_done, b_cs, b_ad, b_wr, b_rd, b_oe;
  logic [7:0] b_rdata, b_bout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(.DATA_W(8), .CNT_W(4), .PHASE_CYC(PA), .GAP_CYC(GA)) dut_a (
    .CLK(clk), .Reset(rst), .start(start_a), .wr_nrd(wr_nrd), .base_addr(base_addr),
    .count(count), .wdata(wdata), .wdata_req(a_wreq), .rdata(a_rdata),
    .rdata_valid(a_rvld), .busy(a_busy), .done(a_done), .CS(a_cs), .AD(a_ad),
    .WR(a_wr), .RD(a_rd), .bus_out(a_bout), .bus_oe(a_oe), .bus_in(bus_in));

  rtc_bus_sequencer #(.DATA_W(8), .CNT_W(4), .PHASE_CYC(PB), .GAP_CYC(GB)) dut_b (
    .CLK(clk), .Reset(rst), .start(start_b), .wr_nrd(wr_nrd), .base_addr(base_addr),
    .count(count), .wdata(wdata), .wdata_req(b_wreq), .rdata(b_rdata),
    .rdata_valid(b_rvld), .busy(b_busy), .done(b_done), .CS(b_cs), .AD(b_ad),
    .WR(b_wr), .RD(b_rd), .bus_out(b_bout), .bus_oe(b_oe), .bus_in(bus_in));

  typedef struct packed {
    logic       busy, done, wreq, rvld, cs, ad, wr, rd, oe;
    logic       bchk;
    logic [7:0] bout;
    logic       rchk;
    logic [7:0] rdat;
    logic       drv_w, drv_b;
    logic [3:0] beat;
  } exp_t;

  typedef struct {
    bit         sel;
    bit         w;
    logic [7:0] addr;
    int         n;
    int         extra;
    int         exp_total;
    int         exp_req;
    int         exp_vld;
    logic [7:0] wb0;
    logic [7:0] rb0;
  } vec_t;

  exp_t       trace[$];
  logic [7:0] wbytes[16];
  logic [7:0] rbytes[16];
  vec_t       vecs[8];

  function automatic exp_t idle_rec();
    exp_t r;
    r = '0;
    r.cs = 1'b1; r.ad = 1'b1; r.wr = 1'b1; r.rd = 1'b1;
    return r;
  endfunction

  function automatic logic [8:0] ctrl_of(exp_t r);
    return {r.busy, r.done, r.wreq, r.rvld, r.cs, r.ad, r.wr, r.rd, r.oe};
  endfunction

  function automatic logic [8:0] obs_ctrl(bit sel);
    if (sel) return {b_busy, b_done, b_wreq, b_rvld, b_cs, b_ad, b_wr, b_rd, b_oe};
    return {a_busy, a_done, a_wreq, a_rvld, a_cs, a_ad, a_wr, a_rd, a_oe};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Expected pin trace: start cycle, n beats, done cycle, then quiet idle cycles.
  task automatic build(input bit sel, input bit w, input logic [7:0] addr, input int n);
    int   p;
    int   g;
    exp_t r;
    p = sel ? PB : PA;
    g = sel ? GB : GA;
    trace.delete();
    trace.push_back(idle_rec());
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < p; i++) begin
        r = idle_rec(); r.busy = 1; r.beat = 4'(b);
        r.cs = 0; r.ad = 0; r.wr = 0; r.oe = 1; r.bchk = 1; r.bout = addr + 8'(b);
        trace.push_back(r);
      end
      for (int i = 0; i < g; i++) begin
        r = idle_rec(); r.busy = 1; r.beat = 4'(b);
        if (w && i == g - 1) begin r.wreq = 1; r.drv_w = 1; end
        trace.push_back(r);
      end
      for (int i = 0; i < p; i++) begin
        r = idle_rec(); r.busy = 1; r.beat = 4'(b); r.cs = 0;
        if (w) begin r.wr = 0; r.oe = 1; r.bchk = 1; r.bout = wbytes[b]; end
        else begin r.rd = 0; r.drv_b = (i == p - 1); end
        trace.push_back(r);
      end
      for (int i = 0; i < g; i++) begin
        r = idle_rec(); r.busy = 1; r.beat = 4'(b);
        if (!w && i == 0) begin r.rvld = 1; r.rchk = 1; r.rdat = rbytes[b]; end
        trace.push_back(r);
      end
    end
    r = idle_rec(); r.done = 1;
    trace.push_back(r);
    for (int i = 0; i < 3; i++) trace.push_back(idle_rec());
  endtask

  task automatic run(input bit sel, input bit w, input logic [7:0] addr, input int n,
                     input int extra, output int done_cyc, output int nreq, output int nvld);
    string tag;
    build(sel, w, addr, n);
    done_cyc = -1; nreq = 0; nvld = 0;
    for (int t = 0; t < trace.size(); t++) begin
      @(posedge clk); #1;
      tag = $sformatf("%s a=%0h n=%0d t=%0d", sel ? "b" : "a", addr, n, t);
      chk({"ctrl ", tag}, 32'(obs_ctrl(sel)), 32'(ctrl_of(trace[t])));
      if (trace[t].bchk) chk({"bus_out ", tag}, 32'(sel ? b_bout : a_bout), 32'(trace[t].bout));
      if (trace[t].rchk) chk({"rdata ", tag}, 32'(sel ? b_rdata : a_rdata), 32'(trace[t].rdat));
      if (sel ? b_done : a_done) done_cyc = t;
      if (sel ? b_wreq : a_wreq) nreq++;
      if (sel ? b_rvld : a_rvld) nvld++;
      start_a = 1'b0;
      start_b = 1'b0;
      if (t == 0 || t == extra) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      if (t == extra) begin
        wr_nrd = ~w; base_addr = ~addr; count = 4'd9;
      end else begin
        wr_nrd = w; base_addr = addr; count = 4'(n);
      end
      wdata  = trace[t].drv_w ? wbytes[trace[t].beat] : 8'($urandom);
      bus_in = trace[t].drv_b ? rbytes[trace[t].beat] : 8'($urandom);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc, nr, nv, n, extra, beat;
    bit   sel, w;
    logic [7:0] addr;
    exp_t idle;

    idle = idle_rec();
    rst = 1'b1;
    start_a = 0; start_b = 0; wr_nrd = 0; base_addr = 0; count = 0; wdata = 0; bus_in = 0;

    vecs[0] = '{0, 1, 8'h21, 1,  -1, 12,  1, 0,  8'h45, 8'h00};
    vecs[1] = '{0, 0, 8'h22, 1,  -1, 12,  0, 1,  8'h00, 8'h59};
    vecs[2] = '{0, 1, 8'hFE, 3,  -1, 32,  3, 0,  8'h11, 8'h00};
    vecs[3] = '{0, 1, 8'h40, 0,  -1, 2,   0, 0,  8'h00, 8'h00};
    vecs[4] = '{0, 0, 8'h10, 2,   7, 22,  0, 2,  8'h00, 8'hC3};
    vecs[5] = '{1, 1, 8'h7F, 2,  -1, 14,  2, 0,  8'h5A, 8'h00};
    vecs[6] = '{1, 0, 8'hFF, 1,  -1, 8,   0, 1,  8'h00, 8'h96};
    vecs[7] = '{0, 0, 8'h00, 15, -1, 152, 0, 15, 8'h00, 8'h3C};

    repeat (2) @(posedge clk);
    #1;
    chk("reset ctrl a", 32'(obs_ctrl(0)), 32'(ctrl_of(idle)));
    chk("reset ctrl b", 32'(obs_ctrl(1)), 32'(ctrl_of(idle)));
    chk("reset bus_out a", 32'(a_bout), 32'h0);
    chk("reset rdata a", 32'(a_rdata), 32'h0);
    chk("reset bus_out b", 32'(b_bout), 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int b = 0; b < 16; b++) begin
        wbytes[b] = 8'($urandom);
        rbytes[b] = 8'($urandom);
      end
      wbytes[0] = vecs[v].wb0;
      rbytes[0] = vecs[v].rb0;
      run(vecs[v].sel, vecs[v].w, vecs[v].addr, vecs[v].n, vecs[v].extra, dc, nr, nv);
      chk($sformatf("vec%0d total cycles", v), 32'(dc + 1), 32'(vecs[v].exp_total));
      chk($sformatf("vec%0d wdata_req pulses", v), 32'(nr), 32'(vecs[v].exp_req));
      chk($sformatf("vec%0d rdata_valid pulses", v), 32'(nv), 32'(vecs[v].exp_vld));
    end

    // Reset in the middle of a write DATA phase.
    wr_nrd = 1; base_addr = 8'h30; count = 4'd1;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      start_a = (t == 0);
      wdata = (t == 5) ? 8'hA5 : 8'($urandom);
    end
    chk("pre-reset CS", 32'(a_cs), 32'h0);
    chk("pre-reset WR", 32'(a_wr), 32'h0);
    chk("pre-reset bus_out", 32'(a_bout), 32'hA5);
    #2 rst = 1'b1;
    #1;
    chk("mid-beat reset ctrl", 32'(obs_ctrl(0)), 32'(ctrl_of(idle)));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset quiet t=%0d", t), 32'(obs_ctrl(0)), 32'(ctrl_of(idle)));
    end
    wbytes[0] = 8'h6E;
    run(0, 1, 8'h31, 1, -1, dc, nr, nv);
    chk("post-reset total cycles", 32'(dc + 1), 32'd12);

    // Randomized transactions on both instances.
    for (int k = 0; k < 40; k++) begin
      sel  = 1'($urandom);
      w    = 1'($urandom);
      addr = 8'($urandom);
      n    = int'($urandom_range(0, 4));
      beat = sel ? 2 * (PB + GB) : 2 * (PA + GA);
      extra = -1;
      if (n > 0 && $urandom_range(0, 1) == 1) extra = int'($urandom_range(1, n * beat));
      for (int b = 0; b < 16; b++) begin
        wbytes[b] = 8'($urandom);
        rbytes[b] = 8'($urandom);
      end
      run(sel, w, addr, n, extra, dc, nr, nv);
      chk($sformatf("rand%0d total cycles", k), 32'(dc + 1), 32'(n * beat + 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
